// File: rtl/hs32_sram_pkg.sv
// Shared HS32 bus contract constants and the SRAM bridge state type.
package hs32_sram_pkg;

  localparam int unsigned HS32_DATA_W = 32;
  localparam int unsigned HALF_W      = 16;
  localparam int unsigned CNT_W       = 4;

  localparam logic HS32_RW_READ  = 1'b0;
  localparam logic HS32_RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/hs32_sram.sv
// HS32 external bus responder driving an async 16-bit SRAM as two halfword
// accesses (low half first) with a configurable strobe width.
module hs32_sram
  import hs32_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 18,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                   i_clk,
  input  logic                   reset_n,
  input  logic [HS32_DATA_W-1:0] addr,
  input  logic                   rw,
  input  logic [HS32_DATA_W-1:0] din,
  output logic [HS32_DATA_W-1:0] dout,
  input  logic                   valid,
  output logic                   ready,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [HALF_W-1:0]      sram_dq_o,
  input  logic [HALF_W-1:0]      sram_dq_i,
  output logic                   sram_dq_oe,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  localparam int unsigned WA_W = ADDR_WIDTH - 1;

  state_e                 state_q, state_d;
  logic                   half_q, half_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WA_W-1:0]        waddr_q, waddr_d;
  logic                   rw_q, rw_d;
  logic [HS32_DATA_W-1:0] wdata_q, wdata_d;
  logic [HS32_DATA_W-1:0] rdata_q, rdata_d;
  logic [HS32_DATA_W-1:0] dout_q, dout_d;
  logic                   ready_q, ready_d;
  logic [ADDR_WIDTH-1:0]  sram_addr_q, sram_addr_d;
  logic [HALF_W-1:0]      dq_o_q, dq_o_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   ce_n_q, ce_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   we_n_q, we_n_d;
  logic                   active_c;

  // Byte-lane bits and address bits above the SRAM range are don't-care (aliasing).
  logic unused_addr_c;
  assign unused_addr_c = ^{addr[HS32_DATA_W-1:ADDR_WIDTH+1], addr[1:0]};

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    dout_d      = dout_q;
    sram_addr_d = sram_addr_q;
    dq_o_d      = dq_o_q;

    unique case (state_q)
      ST_IDLE: begin
        if (valid) begin
          waddr_d = addr[ADDR_WIDTH:2];
          rw_d    = rw;
          wdata_d = din;
          half_d  = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = CNT_W'(WAIT_STATES);
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          if (rw_q == HS32_RW_READ) begin
            if (half_q) rdata_d[31:16] = sram_dq_i;
            else        rdata_d[15:0]  = sram_dq_i;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!half_q) begin
          half_d  = 1'b1;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_DONE;
          if (rw_q == HS32_RW_READ) dout_d = rdata_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pin values are derived from the next state so every output is a flop.
    active_c = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    if (active_c) begin
      sram_addr_d = {waddr_d, half_d};
      if (rw_d == HS32_RW_WRITE) dq_o_d = half_d ? wdata_d[31:16] : wdata_d[15:0];
    end
    ce_n_d  = !active_c;
    dq_oe_d = active_c && (rw_d == HS32_RW_WRITE);
    we_n_d  = !((state_d == ST_STROBE) && (rw_d == HS32_RW_WRITE));
    oe_n_d  = !((state_d == ST_STROBE) && (rw_d == HS32_RW_READ));
    ready_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      half_q      <= 1'b0;
      cnt_q       <= '0;
      waddr_q     <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      dout_q      <= '0;
      ready_q     <= 1'b0;
      sram_addr_q <= '0;
      dq_o_q      <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      cnt_q       <= cnt_d;
      waddr_q     <= waddr_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      dout_q      <= dout_d;
      ready_q     <= ready_d;
      sram_addr_q <= sram_addr_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
    end
  end

  assign dout       = dout_q;
  assign ready      = ready_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;

endmodule
